// File: rtl/write_sram.sv
// Ingress packet writer: fills free DPRAM blocks beat by beat and emits one descriptor per block.
// Optional WRITE_SRAM_PKT_LEN_EN adds o_pkt_len (saturating written-word count) on the last descriptor.
//
// state | meaning
// ALLOC | requesting a free block, port stalled
// WRITE | block held, beats accepted into {blk, unit_count}
module write_sram #(
   parameter  int AWIDTH      = 14,
   parameter  int BLK_AWIDTH  = 10,
   parameter  int DWIDTH      = 32,
   localparam int UNIT_AWIDTH = AWIDTH - BLK_AWIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_sop,
   input  logic                   wr_eop,
   input  logic                   wr_vld,
   input  logic [DWIDTH-1:0]      wr_data,
   output logic                   wr_ready,
   output logic                   o_blk_req,
   input  logic [BLK_AWIDTH-1:0]  i_blk_addr,
   input  logic                   i_blk_addr_vld,
   output logic                   o_sram_wr_en,
   output logic [AWIDTH-1:0]      o_sram_wr_addr,
   output logic [DWIDTH-1:0]      o_sram_wr_data,
   output logic                   o_blk_done_vld,
   output logic [AWIDTH-1:0]      o_blk_done_addr,
   output logic                   o_is_first_blk,
   output logic                   o_is_last_blk,
   output logic [UNIT_AWIDTH-1:0] o_last_blk_n,
   output logic [DWIDTH-1:0]      o_phead,
   output logic                   o_phead_vld,
   output logic                   o_drop
`ifdef WRITE_SRAM_PKT_LEN_EN
   ,
   output logic [15:0]            o_pkt_len
`endif
);

   typedef enum logic {ALLOC, WRITE} state_t;

   state_t                 state;
   logic [BLK_AWIDTH-1:0]  blk;
   logic [UNIT_AWIDTH-1:0] unit_count;
   logic                   in_pkt;
   logic                   first_blk;

   logic accept;
   logic beat_start;
   logic beat_ok;
   logic eff_first;
   logic unit_last;

   assign accept     = wr_vld && wr_ready;
   assign beat_start = !in_pkt && wr_sop;
   // A beat is legal when it opens a packet from idle or continues an open one.
   assign beat_ok    = in_pkt ? !wr_sop : wr_sop;
   assign eff_first  = !in_pkt || first_blk;
   assign unit_last  = &unit_count;

`ifdef WRITE_SRAM_PKT_LEN_EN
   logic [15:0] pkt_len_cnt;
   logic [15:0] len_next;

   assign len_next = beat_start ? 16'd1 :
                     (pkt_len_cnt == 16'hFFFF) ? pkt_len_cnt : pkt_len_cnt + 16'd1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ALLOC;
         blk             <= '0;
         unit_count      <= '0;
         in_pkt          <= 1'b0;
         first_blk       <= 1'b0;
         wr_ready        <= 1'b0;
         o_blk_req       <= 1'b0;
         o_sram_wr_en    <= 1'b0;
         o_sram_wr_addr  <= '0;
         o_sram_wr_data  <= '0;
         o_blk_done_vld  <= 1'b0;
         o_blk_done_addr <= '0;
         o_is_first_blk  <= 1'b0;
         o_is_last_blk   <= 1'b0;
         o_last_blk_n    <= '0;
         o_phead         <= '0;
         o_phead_vld     <= 1'b0;
         o_drop          <= 1'b0;
`ifdef WRITE_SRAM_PKT_LEN_EN
         pkt_len_cnt     <= '0;
         o_pkt_len       <= '0;
`endif
      end else begin
         o_sram_wr_en    <= 1'b0;
         o_sram_wr_addr  <= '0;
         o_sram_wr_data  <= '0;
         o_blk_done_vld  <= 1'b0;
         o_blk_done_addr <= '0;
         o_is_first_blk  <= 1'b0;
         o_is_last_blk   <= 1'b0;
         o_last_blk_n    <= '0;
         o_phead         <= '0;
         o_phead_vld     <= 1'b0;
         o_drop          <= 1'b0;
`ifdef WRITE_SRAM_PKT_LEN_EN
         o_pkt_len       <= '0;
`endif
         case (state)
            ALLOC: begin
               o_blk_req <= 1'b1;
               wr_ready  <= 1'b0;
               if (i_blk_addr_vld) begin
                  blk        <= i_blk_addr;
                  unit_count <= '0;
                  state      <= WRITE;
                  o_blk_req  <= 1'b0;
                  wr_ready   <= 1'b1;
               end
            end
            WRITE: begin
               o_blk_req <= 1'b0;
               wr_ready  <= 1'b1;
               if (accept) begin
                  if (!beat_ok) begin
                     o_drop <= 1'b1;
                  end else begin
                     o_sram_wr_en   <= 1'b1;
                     o_sram_wr_addr <= {blk, unit_count};
                     o_sram_wr_data <= wr_data;
                     unit_count     <= unit_count + 1'b1;
                     if (beat_start) begin
                        o_phead     <= wr_data;
                        o_phead_vld <= 1'b1;
                     end
`ifdef WRITE_SRAM_PKT_LEN_EN
                     pkt_len_cnt <= len_next;
                     if (wr_eop) o_pkt_len <= len_next;
`endif
                     if (wr_eop || unit_last) begin
                        o_blk_done_vld  <= 1'b1;
                        o_blk_done_addr <= {blk, {UNIT_AWIDTH{1'b0}}};
                        o_is_first_blk  <= eff_first;
                        o_is_last_blk   <= wr_eop;
                        o_last_blk_n    <= wr_eop ? unit_count : {UNIT_AWIDTH{1'b1}};
                        state           <= ALLOC;
                        wr_ready        <= 1'b0;
                        o_blk_req       <= 1'b1;
                        in_pkt          <= !wr_eop;
                        first_blk       <= 1'b0;
                     end else begin
                        in_pkt    <= 1'b1;
                        first_blk <= eff_first;
                     end
                  end
               end
            end
            default: state <= ALLOC;
         endcase
      end
   end

endmodule

// File: tb/tb_write_sram.sv
// Scoreboard bench for write_sram: a behavioural block manager grants from a queue and
// expected writes, headers, drops and descriptors are queued as beats are accepted.
module tb_write_sram;
   localparam int AW = 14;
   localparam int BW = 10;
   localparam int DW = 32;
   localparam int UW = AW - BW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_sop, wr_eop, wr_vld;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          o_blk_req;
   logic [BW-1:0] i_blk_addr;
   logic          i_blk_addr_vld;
   logic          o_sram_wr_en;
   logic [AW-1:0] o_sram_wr_addr;
   logic [DW-1:0] o_sram_wr_data;
   logic          o_blk_done_vld;
   logic [AW-1:0] o_blk_done_addr;
   logic          o_is_first_blk, o_is_last_blk;
   logic [UW-1:0] o_last_blk_n;
   logic [DW-1:0] o_phead;
   logic          o_phead_vld;
   logic          o_drop;
`ifdef WRITE_SRAM_PKT_LEN_EN
   logic [15:0]   o_pkt_len;
`endif

   write_sram dut (
      .clk(clk), .rst(rst),
      .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld), .wr_data(wr_data), .wr_ready(wr_ready),
      .o_blk_req(o_blk_req), .i_blk_addr(i_blk_addr), .i_blk_addr_vld(i_blk_addr_vld),
      .o_sram_wr_en(o_sram_wr_en), .o_sram_wr_addr(o_sram_wr_addr), .o_sram_wr_data(o_sram_wr_data),
      .o_blk_done_vld(o_blk_done_vld), .o_blk_done_addr(o_blk_done_addr),
      .o_is_first_blk(o_is_first_blk), .o_is_last_blk(o_is_last_blk), .o_last_blk_n(o_last_blk_n),
      .o_phead(o_phead), .o_phead_vld(o_phead_vld), .o_drop(o_drop)
`ifdef WRITE_SRAM_PKT_LEN_EN
      , .o_pkt_len(o_pkt_len)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // expected traffic
   logic [AW+DW-1:0]  q_wr[$];
   logic [AW+UW+1:0]  q_desc[$];
   logic [DW-1:0]     q_phead[$];
   bit                q_drop[$];
   logic [15:0]       q_len[$];
   logic [BW-1:0]     q_gnt[$];

   // reference model of the current block / packet
   logic [BW-1:0] m_blk = '0;
   logic [UW-1:0] m_unit = '0;
   bit            m_in_pkt = 1'b0;
   bit            m_first = 1'b0;
   logic [15:0]   m_len = '0;

   int gnt_delay = 0;
   int grant_cyc = -1;
   int first_wr_cyc = -1;
   int n_drop_seen = 0;
   int n_desc_seen = 0;

   // block manager
   initial begin
      i_blk_addr     = '0;
      i_blk_addr_vld = 1'b0;
      forever begin
         @(negedge clk);
         if (o_blk_req && !rst && q_gnt.size() > 0) begin
            repeat (gnt_delay) @(negedge clk);
            i_blk_addr     = q_gnt.pop_front();
            i_blk_addr_vld = 1'b1;
            m_blk          = i_blk_addr;
            m_unit         = '0;
            grant_cyc      = cyc;
            @(negedge clk);
            i_blk_addr_vld = 1'b0;
         end
      end
   end

   // output monitor
   always @(negedge clk) begin
      if (o_sram_wr_en) begin
         if (first_wr_cyc < 0) first_wr_cyc = cyc;
         if (q_wr.size() == 0) chk("unexpected_wr", 64'(o_sram_wr_addr), 64'h0);
         else chk("wr_addr_data", 64'({o_sram_wr_addr, o_sram_wr_data}), 64'(q_wr.pop_front()));
      end
      if (o_phead_vld) begin
         if (q_phead.size() == 0) chk("unexpected_phead", 64'(o_phead), 64'h0);
         else chk("phead_with_wr", 64'({o_sram_wr_en, o_phead}), 64'({1'b1, q_phead.pop_front()}));
      end
      if (o_drop) begin
         n_drop_seen++;
         if (q_drop.size() == 0) chk("unexpected_drop", 64'(o_drop), 64'h0);
         else begin
            void'(q_drop.pop_front());
            chk("drop_no_wr", 64'(o_sram_wr_en), 64'h0);
         end
      end
      if (o_blk_done_vld) begin
         n_desc_seen++;
         if (q_desc.size() == 0) chk("unexpected_desc", 64'(o_blk_done_addr), 64'h0);
         else chk("desc", 64'({o_blk_done_addr, o_is_first_blk, o_is_last_blk, o_last_blk_n}),
                  64'(q_desc.pop_front()));
`ifdef WRITE_SRAM_PKT_LEN_EN
         if (o_is_last_blk && q_len.size() > 0) chk("pkt_len", 64'(o_pkt_len), 64'(q_len.pop_front()));
`endif
      end
      if (o_blk_req) chk("ready_in_alloc", 64'(wr_ready), 64'h0);
   end

   task automatic model_beat(input bit sop, input bit eop, input logic [DW-1:0] d);
      bit ok;
      bit ef;
      ok = m_in_pkt ? !sop : sop;
      if (!ok) begin
         q_drop.push_back(1'b1);
         return;
      end
      ef = !m_in_pkt || m_first;
      q_wr.push_back({m_blk, m_unit, d});
      if (!m_in_pkt) begin
         q_phead.push_back(d);
         m_len = '0;
      end
      if (m_len != 16'hFFFF) m_len = m_len + 16'd1;
      if (eop) begin
         q_desc.push_back({m_blk, {UW{1'b0}}, ef, 1'b1, m_unit});
         q_len.push_back(m_len);
         m_in_pkt = 1'b0;
      end else if (m_unit == {UW{1'b1}}) begin
         q_desc.push_back({m_blk, {UW{1'b0}}, ef, 1'b0, {UW{1'b1}}});
         m_first  = 1'b0;
         m_in_pkt = 1'b1;
      end else begin
         m_in_pkt = 1'b1;
         m_first  = ef;
      end
      m_unit = m_unit + 1'b1;
   endtask

   // Presents a beat and holds it until a negedge shows wr_ready; returns just after the accepting edge.
   task automatic send_beat(input bit sop, input bit eop, input logic [DW-1:0] d, output int stalls);
      bit acc;
      acc    = 1'b0;
      stalls = 0;
      wr_vld = 1'b1; wr_sop = sop; wr_eop = eop; wr_data = d;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         if (wr_ready) acc = 1'b1;
         else stalls++;
         @(posedge clk); #2;
      end
      if (!acc) chk("accept_timeout", 64'h0, 64'h1);
      else model_beat(sop, eop, d);
   endtask

   task automatic send_pkt(input int n, input logic [DW-1:0] base);
      int s;
      for (int i = 0; i < n; i++) send_beat(i == 0, i == n - 1, base + DW'(i), s);
      wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0;
   endtask

   task automatic drain(input string tag);
      wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      chk({tag, "_wr_left"},    64'(q_wr.size()), 64'h0);
      chk({tag, "_desc_left"},  64'(q_desc.size()), 64'h0);
      chk({tag, "_phead_left"}, 64'(q_phead.size()), 64'h0);
      chk({tag, "_drop_left"},  64'(q_drop.size()), 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int d0;
      wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0; wr_data = '0;
      gnt_delay = 5;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ctl", 64'({o_blk_req, wr_ready, o_sram_wr_en, o_blk_done_vld, o_phead_vld, o_drop,
                            o_is_first_blk, o_is_last_blk, o_last_blk_n, o_sram_wr_addr, o_blk_done_addr}), 64'h0);
      chk("reset_data", {o_sram_wr_data, o_phead}, 64'h0);

      // 3-beat packet into block 0x005 with the grant held back 5 cycles
      @(posedge clk); #2;
      rst = 1'b0;
      q_gnt.push_back(10'h005);
      send_beat(1'b1, 1'b0, 32'hD000_0000, s);
      chk("stall_before_grant", 64'(s >= 5), 64'h1);
      send_beat(1'b0, 1'b0, 32'hD000_0001, s);
      send_beat(1'b0, 1'b1, 32'hD000_0002, s);
      drain("pkt3");
      chk("first_wr_latency", 64'(first_wr_cyc - grant_cyc), 64'h2);
      gnt_delay = 2;

      // 20-beat packet across blocks 0x010 and 0x011
      q_gnt.push_back(10'h010);
      q_gnt.push_back(10'h011);
      send_pkt(20, 32'hA000_0000);
      drain("pkt20");

      // exactly one full block, eop on the last unit
      q_gnt.push_back(10'h020);
      d0 = n_desc_seen;
      send_pkt(16, 32'hB000_0000);
      drain("pkt16");
      chk("pkt16_one_desc", 64'(n_desc_seen - d0), 64'h1);
      chk("prefetch_req", 64'({o_blk_req, wr_ready}), 64'b10);

      // framing errors: stray beat while idle, nested sop mid-packet
      q_gnt.push_back(10'h030);
      d0 = n_drop_seen;
      send_beat(1'b0, 1'b0, 32'hEEEE_0000, s);
      send_beat(1'b1, 1'b0, 32'hC000_0000, s);
      send_beat(1'b0, 1'b0, 32'hC000_0001, s);
      send_beat(1'b1, 1'b0, 32'hEEEE_0001, s);
      send_beat(1'b0, 1'b0, 32'hC000_0002, s);
      send_beat(1'b0, 1'b1, 32'hC000_0003, s);
      drain("drops");
      chk("drop_count", 64'(n_drop_seen - d0), 64'h2);

      // reset asserted at beat 7 of an open packet
      q_gnt.push_back(10'h040);
      d0 = n_desc_seen;
      send_beat(1'b1, 1'b0, 32'hF000_0000, s);
      for (int i = 1; i < 7; i++) send_beat(1'b0, 1'b0, 32'hF000_0000 + DW'(i), s);
      wr_sop = 1'b0; wr_eop = 1'b0; wr_data = 32'hF000_0007;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      wr_vld = 1'b0;
      m_in_pkt = 1'b0;
      m_first  = 1'b0;
      @(negedge clk);
      chk("midrst_ctl", 64'({o_blk_req, wr_ready, o_sram_wr_en, o_blk_done_vld, o_phead_vld, o_drop,
                             o_is_first_blk, o_is_last_blk, o_last_blk_n, o_sram_wr_addr, o_blk_done_addr}), 64'h0);
      chk("midrst_data", {o_sram_wr_data, o_phead}, 64'h0);
      @(negedge clk);
      chk("after_rst_alloc", 64'({o_blk_req, wr_ready}), 64'b10);
      @(posedge clk); #2;
      chk("midrst_no_desc", 64'(n_desc_seen - d0), 64'h0);
      chk("midrst_wr_left", 64'(q_wr.size()), 64'h0);

      // single-word packet after recovery
      q_gnt.push_back(10'h050);
      send_beat(1'b1, 1'b1, 32'h1234_5678, s);
      drain("pkt1");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/write_sram.md
Name: write_sram

Overview:
- Ingress counterpart of the egress SRAM reader.
- Accepts a framed packet stream (sop/eop/vld/data) from an input port.
- Requests free blocks from the block manager and writes each beat into the shared DPRAM at {block, unit}.
- Emits one descriptor per filled block to the arbiter/queue manager. Descriptor fields are block address, last-block flag and last-unit index, which are exactly the fields the reader consumes.

Parameters:
- AWIDTH, 14, DPRAM word address width (one word = DWIDTH bits).
- BLK_AWIDTH, 10, block address width. UNIT_AWIDTH = AWIDTH-BLK_AWIDTH, so 16 words per block at the defaults.
- DWIDTH, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wr_sop  in  1  first beat of packet.
- wr_eop  in  1  last beat of packet.
- wr_vld  in  1  beat valid.
- wr_data  in  DWIDTH  beat data.
- wr_ready  out  1  beat accepted when wr_vld && wr_ready.
- o_blk_req  out  1  request for a free block.
- i_blk_addr  in  BLK_AWIDTH  granted block.
- i_blk_addr_vld  in  1  grant strobe, 1 cycle.
- o_sram_wr_en  out  1  DPRAM write enable.
- o_sram_wr_addr  out  AWIDTH  {block, unit}.
- o_sram_wr_data  out  DWIDTH  write data.
- o_blk_done_vld  out  1  descriptor strobe.
- o_blk_done_addr  out  AWIDTH  {block, UNIT_AWIDTH'0}.
- o_is_first_blk  out  1  descriptor is the packet's first block.
- o_is_last_blk  out  1  descriptor is the packet's last block.
- o_last_blk_n  out  UNIT_AWIDTH  last written unit index; all-ones when not last.
- o_phead  out  DWIDTH  header word (first beat).
- o_phead_vld  out  1  header strobe.
- o_drop  out  1  framing-error strobe.

Behaviour:
- Reset: all outputs 0, state ALLOC, unit_count=0, in_pkt=0, no block held.
- FSM has two states.
  - ALLOC: o_blk_req=1 and wr_ready=0. On i_blk_addr_vld, latch i_blk_addr, clear unit_count, go to WRITE.
  - WRITE: o_blk_req=0 and wr_ready=1. Grants arriving in WRITE are ignored; the manager must not issue them.
- Accepted beat, when framing is valid:
  - Next cycle (1-cycle latency) drive o_sram_wr_en=1, addr={blk, unit_count}, data=wr_data.
  - unit_count increments, wrapping to 0 at block end.
- Framing rules:
  - Beat with wr_sop while !in_pkt: start a packet. Set in_pkt, first_blk=1. Next cycle o_phead=wr_data and o_phead_vld=1, aligned with the write.
  - Beat without wr_sop while !in_pkt: discard (no write), o_drop=1 next cycle.
  - Beat with wr_sop while in_pkt: discard, o_drop=1 next cycle. The current packet continues.
  - sop&&eop on one beat is a legal 1-word packet.
- Block close, for a valid written beat:
  - If wr_eop: descriptor with last=1, last_blk_n=unit_count, first=first_blk. Clear in_pkt, go to ALLOC.
  - Else if unit_count == all-ones: descriptor with last=0, last_blk_n=all-ones, first=first_blk. Clear first_blk, go to ALLOC. wr_ready falls in the same cycle the state changes.
  - eop on unit all-ones gives a single last=1 descriptor with n=all-ones; no extra block is requested for the packet.
- Descriptor timing: o_blk_done_vld pulses 1 cycle, in the same cycle as that block's final o_sram_wr_en. Descriptors are issued in block order.
- After a packet ends, the FSM prefetches the next block immediately, even when the port is idle.
- wr_ready is a registered state decode. The source must hold wr_vld/data while wr_ready=0.
- Reset mid-packet: the partially written block is abandoned and no descriptor is emitted. The block manager reclaims it on its own reset.
- Strobes (o_sram_wr_en, o_phead_vld, o_blk_done_vld, o_drop) are single-cycle and default to 0. o_phead is 0 when not valid.

Optional Feature:
- WRITE_SRAM_PKT_LEN_EN defined:
  - Adds port o_pkt_len, out, 16 bits: count of written words in the packet.
  - Valid only when o_blk_done_vld && o_is_last_blk, otherwise 0.
  - Counter saturates at 16'hFFFF and clears at each packet start.
- Undefined: the port and counter are absent and all other behaviour is identical.

Test Plan:
- Reset, grant 0x005, 3-beat packet D0..D2 -> writes at 0x0050/0x0051/0x0052; phead=D0 with o_phead_vld on the first write; descriptor addr 0x0050, first=1, last=1, n=2.
- 20-beat packet, grants 0x010 then 0x011 -> descriptor 0x0100 (first=1, last=0, n=15); wr_ready low during ALLOC; descriptor 0x0110 (first=0, last=1, n=3).
- Exactly 16-beat packet, grant 0x020 -> single descriptor 0x0200, last=1, n=15; next o_blk_req only for prefetch.
- Grant withheld 5 cycles after reset with wr_vld=1 -> wr_ready=0, no o_sram_wr_en for 5 cycles; the first write appears 2 cycles after the grant.
- Beat without sop while idle, then sop at beat 2 of an open packet -> o_drop pulses twice, no writes for those beats, packet unit addressing unbroken.
- rst=1 at beat 7 of a packet -> all outputs 0 next cycle, no descriptor, state ALLOC with o_blk_req=1 once rst falls.
